// File: rtl/rip_mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between a data port (1) and a fetch port (2).
// Port 1 wins ties unless it has already taken STARVE_MAX back-to-back grants while port 2 waited.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch operands when a port requests
// ACCESS | mem_req high, waiting for mem_ack
// DONE   | one-cycle completion; granted port sees busy low
`timescale 1ns/1ps
module rip_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STARVE_MAX = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we_1,
    input  logic                  re_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] din_1,
    output logic [DATA_WIDTH-1:0] dout_1,
    output logic                  busy_1,
    input  logic                  re_2,
    input  logic [ADDR_WIDTH-1:0] addr_2,
    output logic [DATA_WIDTH-1:0] dout_2,
    output logic                  busy_2,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int CNT_W = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state, state_nxt;
    logic                  grant_q, grant_nxt;   // 0 = port 1, 1 = port 2
    logic [CNT_W-1:0]      starve_q, starve_nxt;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  req_1, req_2, starved, pick_2, accept;

    assign req_1   = we_1 | re_1;
    assign req_2   = re_2;
    assign starved = (starve_q >= CNT_W'(STARVE_MAX));
    assign pick_2  = req_2 & (~req_1 | starved);
    assign accept  = (state == IDLE) & (req_1 | req_2);

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_q;
        starve_nxt = starve_q;
        case (state)
            IDLE: begin
                if (req_1 | req_2) begin
                    state_nxt = ACCESS;
                    grant_nxt = pick_2;
                    // a port-1 grant with port 2 waiting implies not yet starved, so +1 saturates
                    if (pick_2)
                        starve_nxt = '0;
                    else if (req_2)
                        starve_nxt = starve_q + CNT_W'(1);
                    else
                        starve_nxt = '0;
                end
            end
            ACCESS: if (mem_ack) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            grant_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            state    <= state_nxt;
            grant_q  <= grant_nxt;
            starve_q <= starve_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= ~pick_2 & we_1;
            addr_q  <= pick_2 ? addr_2 : addr_1;
            wdata_q <= pick_2 ? '0 : din_1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_1 <= '0;
            dout_2 <= '0;
        end else if ((state == ACCESS) && mem_ack && !wr_q) begin
            if (grant_q)
                dout_2 <= mem_rdata;
            else
                dout_1 <= mem_rdata;
        end
    end

    assign mem_req   = (state == ACCESS);
    assign mem_we    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign busy_1 = req_1 & ~((state == DONE) & ~grant_q);
    assign busy_2 = req_2 & ~((state == DONE) &  grant_q);

endmodule

// File: tb/tb_rip_mem_arbiter.sv
// Scoreboard bench for rip_mem_arbiter: transaction-level arbitration model plus a behavioural memory.
`timescale 1ns/1ps
module tb_rip_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SM = 2;

    logic          clk = 0;
    logic          rstn;
    logic          we_1, re_1, re_2;
    logic [AW-1:0] addr_1, addr_2;
    logic [DW-1:0] din_1, dout_1, dout_2;
    logic          busy_1, busy_2;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    rip_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rstn(rstn),
        .we_1(we_1), .re_1(re_1), .addr_1(addr_1), .din_1(din_1), .dout_1(dout_1), .busy_1(busy_1),
        .re_2(re_2), .addr_2(addr_2), .dout_2(dout_2), .busy_2(busy_2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // behavioural memory: unwritten words read back as a hash of the address
    logic [31:0] mem_model [logic [31:0]];
    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    bit resp_en = 1;
    int k_mode  = 0;   // <0: random ack delay 0..3
    bit r_busy;
    int r_cnt;

    initial begin
        mem_ack = 0;
        mem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (!resp_en) begin
                r_busy = 0;
                continue;
            end
            mem_ack   = 0;
            mem_rdata = $urandom;
            if (!rstn) r_busy = 0;
            else if (mem_req) begin
                if (!r_busy) begin
                    r_busy = 1;
                    r_cnt  = (k_mode < 0) ? int'($urandom_range(0, 3)) : k_mode;
                end
                if (r_cnt == 0) begin
                    mem_ack = 1;
                    r_busy  = 0;
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else        mem_rdata = model_read(mem_addr);
                end else r_cnt--;
            end
        end
    end

    typedef struct { int port; logic [31:0] dout; } sb_t;
    sb_t         sb[$];
    logic [31:0] addr_log[$];

    int          m_cnt, m_grant;
    logic [31:0] m_dout1, m_dout2;
    bit          p_req1, p_req2, p_we1, p_mreq, in_done;
    logic [31:0] p_addr1, p_addr2, p_din1;

    // monitor: transaction-level arbitration model, per-cycle busy checks, completion checks
    initial begin
        bit r1, r2, ew;
        int g;
        logic [31:0] ea, rd;
        sb_t e;
        forever begin
            @(negedge clk);
            r1 = we_1 | re_1;
            r2 = re_2;
            if (!rstn) begin
                chk("rst_mem_req", 32'(mem_req), 0);
                chk("rst_mem_we", 32'(mem_we), 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_dout_1", dout_1, 0);
                chk("rst_dout_2", dout_2, 0);
                chk("rst_busy_1", 32'(busy_1), 32'(r1));
                chk("rst_busy_2", 32'(busy_2), 32'(r2));
                m_cnt = 0; m_grant = 1; m_dout1 = 0; m_dout2 = 0;
                sb.delete();
                p_mreq = 0; in_done = 0;
            end else begin
                if (in_done) begin
                    if (sb.size() == 0) fail_now("sb_underflow");
                    else begin
                        e = sb.pop_front();
                        chk(e.port == 1 ? "done_dout_1" : "done_dout_2",
                            e.port == 1 ? dout_1 : dout_2, e.dout);
                    end
                end
                chk("busy_1", 32'(busy_1), 32'(r1 && !(in_done && m_grant == 1)));
                chk("busy_2", 32'(busy_2), 32'(r2 && !(in_done && m_grant == 2)));
                if (mem_req && !p_mreq) begin
                    g = (p_req2 && (!p_req1 || m_cnt >= SM)) ? 2 : 1;
                    if (g == 2)      m_cnt = 0;
                    else if (p_req2) m_cnt = (m_cnt + 1 > SM) ? SM : m_cnt + 1;
                    else             m_cnt = 0;
                    ea = (g == 1) ? p_addr1 : p_addr2;
                    ew = (g == 1) && p_we1;
                    chk("mem_addr", mem_addr, ea);
                    chk("mem_we", 32'(mem_we), 32'(ew));
                    if (ew) chk("mem_wdata", mem_wdata, p_din1);
                    if (ew) e.dout = m_dout1;
                    else begin
                        rd = model_read(ea);
                        if (g == 1) m_dout1 = rd; else m_dout2 = rd;
                        e.dout = rd;
                    end
                    e.port = g;
                    sb.push_back(e);
                    addr_log.push_back(mem_addr);
                    m_grant = g;
                end
                in_done = mem_req && mem_ack;
                p_mreq  = mem_req;
            end
            p_req1 = r1; p_req2 = r2; p_we1 = we_1;
            p_addr1 = addr_1; p_addr2 = addr_2; p_din1 = din_1;
        end
    end

    task automatic wait_busy(input int port, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((port == 1 ? busy_1 : busy_2) == 1'b0) begin
                lat = i;
                return;
            end
        end
        fail_now(port == 1 ? "busy_1_release" : "busy_2_release");
    endtask

    task automatic wait_mreq();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req) return;
        end
        fail_now("mem_req_rise");
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !mem_req) return;
        end
        fail_now("drain");
    endtask

    task automatic run_port1(input int n);
        int lat, op, idle;
        for (int t = 0; t < n; t++) begin
            idle = $urandom_range(0, 3);
            if (idle > 0) begin
                we_1 = 0; re_1 = 0;
                repeat (idle) begin @(posedge clk); #1; end
            end
            op = $urandom_range(0, 2);
            we_1 = (op != 0); re_1 = (op != 1);
            addr_1 = 32'($urandom_range(0, 15)) << 2;
            din_1  = $urandom;
            wait_busy(1, lat);
            @(posedge clk); #1;
        end
        we_1 = 0; re_1 = 0;
    endtask

    task automatic run_port2(input int n);
        int lat, idle;
        for (int t = 0; t < n; t++) begin
            idle = $urandom_range(0, 3);
            if (idle > 0) begin
                re_2 = 0;
                repeat (idle) begin @(posedge clk); #1; end
            end
            re_2 = 1;
            addr_2 = 32'($urandom_range(0, 15)) << 2;
            wait_busy(2, lat);
            @(posedge clk); #1;
        end
        re_2 = 0;
    endtask

    initial begin
        int lat, base;
        logic [31:0] starve_exp [6];
        starve_exp = '{32'h40, 32'h40, 32'h80, 32'h40, 32'h40, 32'h80};
        rstn = 0; we_1 = 0; re_1 = 0; re_2 = 0;
        addr_1 = 0; addr_2 = 0; din_1 = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;

        // single read, k=2
        k_mode = 2;
        mem_model[32'h100] = 32'hDEAD_BEEF;
        @(posedge clk); #1 re_2 = 1; addr_2 = 32'h100;
        wait_busy(2, lat);
        chk("rd_latency", 32'(lat), 4);
        chk("rd_dout_2", dout_2, 32'hDEAD_BEEF);
        @(posedge clk); #1 re_2 = 0;

        // simultaneous requests, port 1 first
        k_mode = 1;
        base = addr_log.size();
        @(posedge clk); #1 we_1 = 1; addr_1 = 32'h20; din_1 = 32'h55; re_2 = 1; addr_2 = 32'h24;
        wait_busy(1, lat);
        chk("sim_lat_1", 32'(lat), 3);
        chk("sim_busy_2_held", 32'(busy_2), 1);
        @(posedge clk); #1 we_1 = 0;
        wait_busy(2, lat);
        chk("sim_lat_2", 32'(lat), 3);
        @(posedge clk); #1 re_2 = 0;
        wait_quiet();
        chk("sim_first_addr", addr_log[base], 32'h20);
        chk("sim_second_addr", addr_log[base + 1], 32'h24);

        // starvation guard: both ports held
        k_mode = -1;
        base = addr_log.size();
        @(posedge clk); #1 re_1 = 1; addr_1 = 32'h40; re_2 = 1; addr_2 = 32'h80;
        for (int i = 0; i < 400 && addr_log.size() < base + 6; i++) @(negedge clk);
        if (addr_log.size() < base + 6) fail_now("starve_grants");
        @(posedge clk); #1 re_1 = 0; re_2 = 0;
        wait_quiet();
        for (int i = 0; i < 6; i++)
            if (base + i < addr_log.size())
                chk($sformatf("starve_grant_%0d", i), addr_log[base + i], starve_exp[i]);

        // read-write collision with immediate ack
        k_mode = 0;
        @(posedge clk); #1 we_1 = 1; re_1 = 1; addr_1 = 32'h30; din_1 = 32'h77;
        wait_busy(1, lat);
        chk("coll_latency", 32'(lat), 2);
        chk("coll_dout_1", dout_1, m_dout1);
        @(posedge clk); #1 we_1 = 0; re_1 = 0;
        wait_quiet();

        // dropped request during ACCESS
        k_mode = 3;
        @(posedge clk); #1 re_1 = 1; addr_1 = 32'h50;
        wait_mreq();
        @(posedge clk); #1 re_1 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("drop_mem_req", 32'(mem_req), 1);
            chk("drop_busy_1", 32'(busy_1), 0);
            if (mem_ack) break;
        end
        @(negedge clk);
        chk("drop_dout_1", dout_1, model_read(32'h50));
        wait_quiet();

        // reset mid-access, late ack, then a normal request
        resp_en = 0;
        @(posedge clk); #1 re_2 = 1; addr_2 = 32'h200;
        wait_mreq();
        @(posedge clk); #2 rstn = 0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 0);
        chk("rst_mid_dout_1", dout_1, 0);
        chk("rst_mid_dout_2", dout_2, 0);
        @(negedge clk);
        chk("rst_mid_busy_2", 32'(busy_2), 1);
        @(posedge clk); #1 re_2 = 0;
        @(negedge clk); #1 rstn = 1;
        @(posedge clk); #1 mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("late_ack_mem_req", 32'(mem_req), 0);
        @(posedge clk); #1 mem_ack = 0;
        @(negedge clk);
        chk("late_ack_dout_1", dout_1, 0);
        chk("late_ack_dout_2", dout_2, 0);
        chk("late_ack_mem_req2", 32'(mem_req), 0);
        resp_en = 1;
        k_mode = 1;
        @(posedge clk); #1 re_1 = 1; addr_1 = 32'h34;
        wait_busy(1, lat);
        chk("post_rst_latency", 32'(lat), 3);
        chk("post_rst_dout_1", dout_1, model_read(32'h34));
        @(posedge clk); #1 re_1 = 0;
        wait_quiet();

        // randomized traffic on both ports
        k_mode = -1;
        @(posedge clk); #1;
        fork
            run_port1(60);
            run_port2(60);
        join
        wait_quiet();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rip_mem_arbiter.md
RIP_MEM_ARBITER -- requirements
Module: rip_mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, data width of every data port; ADDR_WIDTH, default 32, byte-address width; STARVE_MAX, default 2, the number of consecutive port-1 grants allowed while port 2 waits.
REQ-002 clk, input, 1: the single clock; every register SHALL update on its rising edge.
REQ-003 rstn, input, 1: reset, asynchronous and active-low.
REQ-004 we_1 / re_1, input, 1 each: port-1 (data stage) write request and read request.
REQ-005 addr_1, input, ADDR_WIDTH: port-1 byte address. din_1, input, DATA_WIDTH: port-1 write data.
REQ-006 dout_1, output, DATA_WIDTH: port-1 read data, registered. busy_1, output, 1: port-1 stall.
REQ-007 re_2, input, 1: port-2 (fetch) read request. addr_2, input, ADDR_WIDTH: port-2 byte address.
REQ-008 dout_2, output, DATA_WIDTH: port-2 read data, registered. busy_2, output, 1: port-2 stall.
REQ-009 Memory-side signals SHALL be: mem_req, output, 1; mem_we, output, 1; mem_addr, output, ADDR_WIDTH; mem_wdata, output, DATA_WIDTH; mem_rdata, input, DATA_WIDTH; mem_ack, input, 1, a single-cycle completion pulse.

Function
REQ-010 The block SHALL share one single-port memory between port 1 and port 2, with one transaction in flight at a time.
REQ-011 The FSM SHALL have three states:
  - IDLE: no transaction.
  - ACCESS: memory request outstanding.
  - DONE: one-cycle completion.
REQ-012 A port SHALL be considered requesting when any of its request inputs is high; requesters SHALL hold request and operands stable while their busy output is high.
REQ-013 In IDLE with at least one port requesting, the block SHALL:
  - latch the grant, address, write data and write flag;
  - move to ACCESS on the next edge.
REQ-014 Arbitration SHALL grant port 1 when both ports request, except when port 1 has received STARVE_MAX consecutive grants while port 2 was requesting; in that case it SHALL grant port 2.
REQ-015 The consecutive-grant counter SHALL:
  - clear on any port-2 grant;
  - clear on any port-1 grant made while port 2 is idle;
  - saturate at STARVE_MAX.
REQ-016 When we_1 and re_1 are both high, the block SHALL perform a write; mem_we SHALL equal the latched write flag.
REQ-017 In ACCESS, mem_req SHALL be high and mem_addr/mem_wdata/mem_we SHALL be driven from the latched values, stable until mem_ack.
REQ-018 On mem_ack in ACCESS, the block SHALL:
  - load mem_rdata into dout of the granted port when the transaction is a read (a write leaves dout unchanged);
  - go to DONE on the same edge.
REQ-019 mem_req SHALL be low in IDLE and DONE; mem_ack outside ACCESS SHALL be ignored.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE; arbitration for the next transaction SHALL occur in that IDLE cycle.
REQ-021 busy_n SHALL be combinational: (port n requesting) AND NOT (state==DONE AND grant==n). An idle port SHALL see busy low.
REQ-022 Latency from request (IDLE, no competitor) to busy low SHALL be 2+k cycles, where k is the number of cycles from mem_req rising to mem_ack (k>=0; mem_ack is allowed in the first ACCESS cycle).
REQ-023 A requester that drops its request during ACCESS SHALL NOT abort the transaction; the transaction SHALL complete normally and dout SHALL still update.
REQ-024 A port's dout SHALL hold its value until that port's next completed read.

Reset
REQ-025 While rstn is low, the block SHALL force:
  - state to IDLE;
  - mem_req, mem_we, mem_addr, mem_wdata to 0;
  - dout_1 and dout_2 to 0;
  - the grant to port 1 and the starvation counter to 0.
REQ-026 Reset asserted during ACCESS SHALL abandon the transaction immediately; a mem_ack arriving after reset release SHALL be ignored because the state is IDLE.
REQ-027 busy_n after reset SHALL follow REQ-021 only, so a port holding a request during reset sees busy high.

Verification
REQ-028 Single read:
  - Stimulus: re_2=1, addr_2=0x100; memory acks 2 cycles after mem_req with 0xDEADBEEF.
  - Response: mem_addr=0x100, mem_we=0; busy_2 low in cycle 4; dout_2=0xDEADBEEF.
REQ-029 Simultaneous requests:
  - Stimulus: we_1=1, addr_1=0x20, din_1=0x55 and re_2=1 in the same cycle.
  - Response: first transaction is a write to 0x20 with data 0x55; port 2 is served next; busy_2 stays high throughout the port-1 transaction.
REQ-030 Starvation guard:
  - Stimulus: re_1 and re_2 held continuously, STARVE_MAX=2.
  - Response: grant sequence 1,1,2,1,1,2.
REQ-031 Read-write collision:
  - Stimulus: we_1=1 and re_1=1 with an immediate ack (k=0).
  - Response: mem_we=1; dout_1 unchanged; busy_1 low on the 2nd cycle after the request.
REQ-032 Reset mid-access:
  - Stimulus: rstn pulsed low during ACCESS, then a late mem_ack.
  - Response: mem_req drops immediately; dout values are 0; the late ack is ignored; a new request is served normally.
REQ-033 Dropped request:
  - Stimulus: re_1 dropped during ACCESS.
  - Response: mem_req is held until ack; dout_1 updates; busy_1 stays low.
